cordic_angle_frontend: RTL and testbench

// - Upstream control stage for the 16-iteration CORDIC sine/cosine core. Accepts any signed angle in degrees x1e7.
// - Wraps the angle to (-180,180], then folds it to [-90,90].
// - Drives the core's s/angle/done handshake and latches the results.
// - Sign-corrects cosine for folded quadrants and presents sine/cosine, scaled x1e7, with a one-cycle valid pulse.

---
 rtl/cordic_angle_frontend_if.sv | 29 ++
 rtl/cordic_angle_frontend.sv | 158 +++++++++++++++
 tb/tb_cordic_angle_frontend.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cordic_angle_frontend_if.sv
// Host and CORDIC-core signal bundle for cordic_angle_frontend.
// The slave modport is the frontend's view; master is the environment
// (host request side plus the core it drives).
interface cordic_angle_frontend_if;
  // host request / result side
  logic               start;
  logic signed [31:0] angle_in;
  logic               busy;
  logic               valid;
  logic               err;
  logic signed [31:0] sine_out;
  logic signed [31:0] cosine_out;
  // CORDIC core side
  logic               cordic_s;
  logic signed [31:0] cordic_angle;
  logic               cordic_done;
  logic signed [31:0] cordic_sine;
  logic signed [31:0] cordic_cosine;

  modport slave (
    input  start, angle_in, cordic_done, cordic_sine, cordic_cosine,
    output busy, valid, err, sine_out, cosine_out, cordic_s, cordic_angle
  );

  modport master (
    output start, angle_in, cordic_done, cordic_sine, cordic_cosine,
    input  busy, valid, err, sine_out, cosine_out, cordic_s, cordic_angle
  );
endinterface

// File: rtl/cordic_angle_frontend.sv
// Angle range-reduction and handshake frontend for a 16-iteration CORDIC
// sine/cosine core. Angles are signed degrees x1e7.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for start; captures angle_in
// WRAP    | one +/-360 step per cycle until angle is in (-180,180]
// FOLD    | fold into [-90,90], note cosine sign, raise cordic_s
// RUN     | hold cordic_s, wait for cordic_done or timeout
// RELEASE | cordic_s low, wait for core to drop cordic_done
module cordic_angle_frontend #(
  parameter logic signed [32:0] DEG180  = 33'sd1800000000,
  parameter int                 TIMEOUT = 40
) (
  input logic                    clk,
  input logic                    rst,
  cordic_angle_frontend_if.slave bus
);

  localparam logic signed [32:0] DEG360 = DEG180 * 2;
  localparam logic signed [32:0] DEG90  = DEG180 / 2;
  localparam int                 CW     = $clog2(TIMEOUT);
  localparam logic [CW-1:0]      TMO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRAP    = 3'd1,
    FOLD    = 3'd2,
    RUN     = 3'd3,
    RELEASE = 3'd4
  } state_t;

  state_t             state_q,        state_d;
  // one guard bit so a +/- DEG360 step never overflows
  logic signed [32:0] a_q,            a_d;
  logic               negcos_q,       negcos_d;
  logic [CW-1:0]      cnt_q,          cnt_d;
  logic               cordic_s_q,     cordic_s_d;
  logic signed [31:0] cordic_angle_q, cordic_angle_d;
  logic signed [31:0] sine_q,         sine_d;
  logic signed [31:0] cosine_q,       cosine_d;
  logic               valid_q,        valid_d;
  logic               err_q,          err_d;

  // state and datapath registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= IDLE;
      a_q            <= '0;
      negcos_q       <= 1'b0;
      cnt_q          <= '0;
      cordic_s_q     <= 1'b0;
      cordic_angle_q <= '0;
      sine_q         <= '0;
      cosine_q       <= '0;
      valid_q        <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      a_q            <= a_d;
      negcos_q       <= negcos_d;
      cnt_q          <= cnt_d;
      cordic_s_q     <= cordic_s_d;
      cordic_angle_q <= cordic_angle_d;
      sine_q         <= sine_d;
      cosine_q       <= cosine_d;
      valid_q        <= valid_d;
      err_q          <= err_d;
    end
  end

  // next-state and datapath updates for each phase of the reduction
  always_comb begin
    state_d        = state_q;
    a_d            = a_q;
    negcos_d       = negcos_q;
    cnt_d          = cnt_q;
    cordic_s_d     = cordic_s_q;
    cordic_angle_d = cordic_angle_q;
    sine_d         = sine_q;
    cosine_d       = cosine_q;
    valid_d        = 1'b0;
    err_d          = err_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = {bus.angle_in[31], bus.angle_in};
          err_d   = 1'b0;
          state_d = WRAP;
        end
      end

      WRAP: begin
        if (a_q > DEG180) begin
          a_d = a_q - DEG360;
        end else if (a_q <= -DEG180) begin
          a_d = a_q + DEG360;
        end else begin
          state_d = FOLD;
        end
      end

      FOLD: begin
        // the reflected angles land in [0,90] / [-90,0], so 32 bits suffice
        if (a_q > DEG90) begin
          cordic_angle_d = 32'(DEG180 - a_q);
          negcos_d       = 1'b1;
        end else if (a_q < -DEG90) begin
          cordic_angle_d = 32'(-DEG180 - a_q);
          negcos_d       = 1'b1;
        end else begin
          cordic_angle_d = a_q[31:0];
          negcos_d       = 1'b0;
        end
        cnt_d      = '0;
        cordic_s_d = 1'b1;
        state_d    = RUN;
      end

      RUN: begin
        if (bus.cordic_done) begin
          sine_d     = bus.cordic_sine;
          cosine_d   = negcos_q ? -bus.cordic_cosine : bus.cordic_cosine;
          valid_d    = 1'b1;
          cordic_s_d = 1'b0;
          state_d    = RELEASE;
        end else if (cnt_q == TMO_LAST) begin
          err_d      = 1'b1;
          sine_d     = '0;
          cosine_d   = '0;
          valid_d    = 1'b1;
          cordic_s_d = 1'b0;
          state_d    = RELEASE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RELEASE: begin
        if (!bus.cordic_done) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.busy         = (state_q != IDLE);
  assign bus.valid        = valid_q;
  assign bus.err          = err_q;
  assign bus.sine_out     = sine_q;
  assign bus.cosine_out   = cosine_q;
  assign bus.cordic_s     = cordic_s_q;
  assign bus.cordic_angle = cordic_angle_q;

endmodule

// File: tb/tb_cordic_angle_frontend.sv
// Bench for cordic_angle_frontend: behavioural CORDIC core plus a
// scoreboard of expected sine/cosine computed from the unreduced angle.
module tb_cordic_angle_frontend;

  localparam real PI  = 3.14159265358979323846;
  localparam int  TOL = 5000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cordic_angle_frontend_if bus ();

  cordic_angle_frontend dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic               start_r    = 1'b0;
  logic signed [31:0] angle_r    = '0;
  logic               core_done  = 1'b0;
  logic signed [31:0] core_sine  = '0;
  logic signed [31:0] core_cos   = '0;
  assign bus.start         = start_r;
  assign bus.angle_in      = angle_r;
  assign bus.cordic_done   = core_done;
  assign bus.cordic_sine   = core_sine;
  assign bus.cordic_cosine = core_cos;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;
  int n_valid     = 0;
  bit done_en     = 1'b1;
  int core_cnt    = 0;

  typedef struct {
    int s;
    int c;
    bit e;
    int at;
    bit ca_chk;
    int ca;
  } exp_t;
  exp_t sb[$];

  function automatic int trig_e7(input int deg_e7, input bit want_cos);
    real r;
    r = (real'(deg_e7) / 1.0e7) * PI / 180.0;
    if (want_cos) return int'($floor(1.0e7 * $cos(r) + 0.5));
    return int'($floor(1.0e7 * $sin(r) + 0.5));
  endfunction

  function automatic int absdiff(input int a, input int b);
    longint d;
    d = longint'(a) - longint'(b);
    return (d < 0) ? int'(-d) : int'(d);
  endfunction

  // behavioural core: done rises so that it is sampled 18 edges after cordic_s
  always @(posedge clk) begin
    if (!bus.cordic_s) begin
      core_cnt  <= 0;
      core_done <= 1'b0;
    end else begin
      core_cnt <= core_cnt + 1;
      if (done_en && core_cnt == 16) begin
        core_done <= 1'b1;
        core_sine <= trig_e7(bus.cordic_angle, 1'b0);
        core_cos  <= trig_e7(bus.cordic_angle, 1'b1);
      end
    end
  end

  // scoreboard: pop and compare on every valid pulse
  always @(negedge clk) begin
    exp_t e;
    if (rst && bus.valid) begin
      n_valid++;
      if (sb.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL unexpected_valid at cyc %0d sine=%0d cos=%0d", cyc, bus.sine_out, bus.cosine_out);
      end else begin
        e = sb.pop_front();
        vectors++;
        if (absdiff(bus.sine_out, e.s) > TOL) begin
          miscompares++;
          $display("FAIL sine got %0d want %0d", bus.sine_out, e.s);
        end
        vectors++;
        if (absdiff(bus.cosine_out, e.c) > TOL) begin
          miscompares++;
          $display("FAIL cosine got %0d want %0d", bus.cosine_out, e.c);
        end
        vectors++;
        if (bus.err !== e.e) begin
          miscompares++;
          $display("FAIL err got %0b want %0b", bus.err, e.e);
        end
        vectors++;
        if (cyc !== e.at) begin
          miscompares++;
          $display("FAIL latency valid at cyc %0d want %0d", cyc, e.at);
        end
        if (e.ca_chk) begin
          vectors++;
          if (bus.cordic_angle !== e.ca) begin
            miscompares++;
            $display("FAIL cordic_angle got %0d want %0d", bus.cordic_angle, e.ca);
          end
        end
      end
    end
  end

  task automatic wait_idle();
    int k = 0;
    while ((bus.busy || sb.size() != 0) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) begin
      vectors++; miscompares++;
      $display("FAIL wait_idle timeout busy=%0b pending=%0d", bus.busy, sb.size());
      sb.delete();
    end
  endtask

  // push expectation and issue a one-cycle start at the next negedge
  task automatic launch(input int ang, input bit ca_chk, input int ca);
    exp_t e;
    int   w;
    w = (ang > 1800000000 || ang <= -1800000000) ? 1 : 0;
    @(negedge clk);
    e.s      = done_en ? trig_e7(ang, 1'b0) : 0;
    e.c      = done_en ? trig_e7(ang, 1'b1) : 0;
    e.e      = !done_en;
    e.at     = cyc + 1 + (done_en ? 20 : 42) + w;
    e.ca_chk = ca_chk;
    e.ca     = ca;
    sb.push_back(e);
    start_r = 1'b1;
    angle_r = ang;
    @(negedge clk);
    start_r = 1'b0;
  endtask

  task automatic apply(input int ang, input bit ca_chk, input int ca);
    launch(ang, ca_chk, ca);
    wait_idle();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %0b want 0", bus.busy); end
    vectors++; if (bus.valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %0b want 0", bus.valid); end
    vectors++; if (bus.err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %0b want 0", bus.err); end
    vectors++; if (bus.sine_out !== 32'sd0) begin miscompares++; $display("FAIL reset_sine got %0d want 0", bus.sine_out); end
    vectors++; if (bus.cosine_out !== 32'sd0) begin miscompares++; $display("FAIL reset_cos got %0d want 0", bus.cosine_out); end
    vectors++; if (bus.cordic_s !== 1'b0) begin miscompares++; $display("FAIL reset_cordic_s got %0b want 0", bus.cordic_s); end
    vectors++; if (bus.cordic_angle !== 32'sd0) begin miscompares++; $display("FAIL reset_cordic_angle got %0d want 0", bus.cordic_angle); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    apply(300000000, 1'b1, 300000000);
    apply(1500000000, 1'b1, 300000000);
    apply(-2000000000, 1'b1, 200000000);
    apply(0, 1'b1, 0);
    apply(-300000000, 1'b1, -300000000);
    apply(-1500000000, 1'b1, -300000000);
  endtask

  task automatic test_boundaries();
    apply(900000000, 1'b1, 900000000);
    apply(-900000000, 1'b1, -900000000);
    apply(1800000000, 1'b1, 0);
    apply(-1800000000, 1'b1, 0);
    apply(2147483647, 1'b0, 0);
    apply(-2147483647 - 1, 1'b0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) apply(int'($urandom), 1'b0, 0);
  endtask

  task automatic test_timeout();
    done_en = 1'b0;
    apply(450000000, 1'b0, 0);
    repeat (3) @(negedge clk);
    vectors++; if (bus.err !== 1'b1) begin miscompares++; $display("FAIL timeout_err_hold got %0b want 1", bus.err); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL timeout_idle busy got %0b want 0", bus.busy); end
    done_en = 1'b1;
    launch(450000000, 1'b1, 450000000);
    vectors++; if (bus.err !== 1'b0) begin miscompares++; $display("FAIL err_clear got %0b want 0", bus.err); end
    wait_idle();
  endtask

  task automatic test_busy_ignore();
    int nv;
    nv = n_valid;
    launch(600000000, 1'b1, 600000000);
    for (int i = 0; i < 12; i++) begin
      start_r = i[0];
      angle_r = -1000000000;
      @(negedge clk);
    end
    start_r = 1'b0;
    wait_idle();
    repeat (5) @(negedge clk);
    vectors++;
    if (n_valid - nv !== 1) begin
      miscompares++;
      $display("FAIL busy_ignore valids got %0d want 1", n_valid - nv);
    end
  endtask

  task automatic test_back_to_back();
    int nv;
    nv = n_valid;
    apply(1200000000, 1'b1, 600000000);
    apply(-600000000, 1'b1, -600000000);
    apply(1700000000, 1'b1, 100000000);
    vectors++;
    if (n_valid - nv !== 3) begin
      miscompares++;
      $display("FAIL back_to_back valids got %0d want 3", n_valid - nv);
    end
  endtask

  task automatic test_mid_reset();
    int nv;
    @(negedge clk);
    start_r = 1'b1;
    angle_r = 300000000;
    @(negedge clk);
    start_r = 1'b0;
    repeat (8) @(negedge clk);
    vectors++;
    if (bus.cordic_s !== 1'b1) begin miscompares++; $display("FAIL midrst_pre cordic_s got %0b want 1", bus.cordic_s); end
    nv = n_valid;
    rst = 1'b0;
    @(negedge clk);
    vectors++; if (bus.cordic_s !== 1'b0) begin miscompares++; $display("FAIL midrst_cordic_s got %0b want 0", bus.cordic_s); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy got %0b want 0", bus.busy); end
    vectors++; if (bus.sine_out !== 32'sd0) begin miscompares++; $display("FAIL midrst_sine got %0d want 0", bus.sine_out); end
    vectors++; if (bus.cosine_out !== 32'sd0) begin miscompares++; $display("FAIL midrst_cos got %0d want 0", bus.cosine_out); end
    vectors++; if (bus.cordic_angle !== 32'sd0) begin miscompares++; $display("FAIL midrst_cordic_angle got %0d want 0", bus.cordic_angle); end
    rst = 1'b1;
    repeat (30) @(negedge clk);
    vectors++;
    if (n_valid !== nv) begin miscompares++; $display("FAIL midrst_no_valid got %0d want %0d", n_valid, nv); end
    apply(-450000000, 1'b1, -450000000);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_random();
    test_timeout();
    test_busy_ignore();
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
